// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS main controller.
// Optional feature macro: MC_IMM_LOGIC_EN (andi/ori via the IMMEX state).
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTEXEC, S_RTWB, S_BEQEX, S_ADDIEX, S_ITWB, S_JEX, S_IMMEX
    } state_t;

    localparam logic [1:0] ALUB_REG   = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       wemem;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       werf;
        logic       rfwasrc;
        logic       mem_to_rf;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

    // States whose exit back to FETCH completes an instruction
    function automatic logic is_terminal(input state_t s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RTWB) ||
               (s == S_BEQEX) || (s == S_ITWB)  || (s == S_JEX);
    endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: opcode/memory handshake in, control out.
interface mc_if #(parameter int CNT_W = 32) ();
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             mem_req;
    logic             wemem;
    logic             iord;
    logic             irwrite;
    logic             pcwrite;
    logic             branch;
    logic [1:0]       pcsrc;
    logic             werf;
    logic             rfwasrc;
    logic             memToRf;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       aluop;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, mem_ready,
        output mem_req, wemem, iord, irwrite, pcwrite, branch, pcsrc,
               werf, rfwasrc, memToRf, alusrca, alusrcb, aluop, illegal, retired
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, wemem, iord, irwrite, pcwrite, branch, pcsrc,
               werf, rfwasrc, memToRf, alusrca, alusrcb, aluop, illegal, retired
    );
endinterface

// File: rtl/mc_out_decode.sv
// State-to-control mapping for the multicycle controller (pure combinational).
// Optional feature macro: MC_IMM_LOGIC_EN (adds the IMMEX row).
module mc_out_decode
    import mc_pkg::*;
(
    input  state_t state,
    input  logic   mem_rdy,
    output ctrl_t  ctrl
);

    // Moore control word per state; FETCH only commits PC/IR on the ready cycle
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = ALUB_FOUR;
                ctrl.irwrite = mem_rdy;
                ctrl.pcwrite = mem_rdy;
            end
            S_DECODE:  ctrl.alusrcb = ALUB_IMMSH;
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.werf      = 1'b1;
                ctrl.mem_to_rf = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                ctrl.wemem   = 1'b1;
            end
            S_RTEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTWB: begin
                ctrl.werf    = 1'b1;
                ctrl.rfwasrc = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.branch  = 1'b1;
                ctrl.pcsrc   = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUB_IMM;
            end
            S_ITWB:    ctrl.werf = 1'b1;
            S_JEX: begin
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = PCSRC_JUMP;
            end
`ifdef MC_IMM_LOGIC_EN
            S_IMMEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUB_IMM;
                ctrl.aluop   = ALUOP_LOGIC;
            end
`endif
            default:   ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_controller.sv
// Multicycle MIPS main controller: FSM, illegal-opcode pulse, retired counter.
// Optional feature macro: MC_IMM_LOGIC_EN (andi/ori decoded to IMMEX).
module mc_main_controller
    import mc_pkg::*;
#(
    parameter bit MEM_HS = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic clk,
    input  logic rst_n,
    mc_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state_q, state_n;
    logic             mem_rdy;
    logic             illegal_d;
    logic [CNT_W-1:0] cnt_q;
    ctrl_t            ctrl;

    // Without a handshake the memory always completes in one cycle
    assign mem_rdy = MEM_HS ? bus.mem_ready : 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_n;
    end

    // Next-state selection; opcode is only looked at in DECODE and MEMADR
    always_comb begin
        state_n   = S_FETCH;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  state_n = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_RTYPE:     state_n = S_RTEXEC;
                    OP_BEQ:       state_n = S_BEQEX;
                    OP_ADDI:      state_n = S_ADDIEX;
                    OP_J:         state_n = S_JEX;
`ifdef MC_IMM_LOGIC_EN
                    OP_ANDI, OP_ORI: state_n = S_IMMEX;
`endif
                    default: begin
                        state_n   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_n = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_n = mem_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_n = mem_rdy ? S_FETCH : S_MEMWR;
            S_RTEXEC: state_n = S_RTWB;
            S_ADDIEX: state_n = S_ITWB;
`ifdef MC_IMM_LOGIC_EN
            S_IMMEX:  state_n = S_ITWB;
`endif
            default:  state_n = S_FETCH;
        endcase
    end

    // Control outputs decoded from the current state
    mc_out_decode u_dec (
        .state   (state_q),
        .mem_rdy (mem_rdy),
        .ctrl    (ctrl)
    );

    // Retired counter: bump on each completed instruction, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        cnt_q <= '0;
        else if (is_terminal(state_q) && state_n == S_FETCH) cnt_q <= cnt_q + CNT_ONE;
    end

    assign bus.mem_req = ctrl.mem_req;
    assign bus.wemem   = ctrl.wemem;
    assign bus.iord    = ctrl.iord;
    assign bus.irwrite = ctrl.irwrite;
    assign bus.pcwrite = ctrl.pcwrite;
    assign bus.branch  = ctrl.branch;
    assign bus.pcsrc   = ctrl.pcsrc;
    assign bus.werf    = ctrl.werf;
    assign bus.rfwasrc = ctrl.rfwasrc;
    assign bus.memToRf = ctrl.mem_to_rf;
    assign bus.alusrca = ctrl.alusrca;
    assign bus.alusrcb = ctrl.alusrcb;
    assign bus.aluop   = ctrl.aluop;
    assign bus.illegal = illegal_d;
    assign bus.retired = cnt_q;

endmodule

// File: tb/tb_mc_main_controller.sv
// Bench for mc_main_controller: per-cycle control words checked against a
// phase-list model of each instruction. Honours MC_IMM_LOGIC_EN if defined.
module tb_mc_main_controller;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
    localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101;

    logic clk = 1'b0;
    logic rst_na = 1'b0;
    logic rst_nb = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] model_ret = 0;

    always #5 clk = ~clk;

    mc_if #(.CNT_W(32)) ifa ();
    mc_if #(.CNT_W(4))  ifb ();

    mc_main_controller #(.MEM_HS(1'b1), .CNT_W(32)) dut_a (.clk(clk), .rst_n(rst_na), .bus(ifa));
    mc_main_controller #(.MEM_HS(1'b0), .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_nb), .bus(ifb));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Control word the spec requires in a named phase
    function automatic logic [15:0] exp_ctrl(input string ph, input bit rdy);
        logic mreq, we, io, irw, pcw, br, wrf, rfw, m2r, asa;
        logic [1:0] pcs, asb, aop;
        {mreq, we, io, irw, pcw, br, wrf, rfw, m2r, asa} = '0;
        pcs = 2'b00; asb = 2'b00; aop = 2'b00;
        if (ph == "FETCH")       begin mreq = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
        else if (ph == "DECODE") asb = 2'b11;
        else if (ph == "MEMADR") begin asa = 1; asb = 2'b10; end
        else if (ph == "MEMRD")  begin mreq = 1; io = 1; end
        else if (ph == "MEMWB")  begin wrf = 1; m2r = 1; end
        else if (ph == "MEMWR")  begin mreq = 1; io = 1; we = 1; end
        else if (ph == "RTEXEC") begin asa = 1; aop = 2'b10; end
        else if (ph == "RTWB")   begin wrf = 1; rfw = 1; end
        else if (ph == "BEQEX")  begin asa = 1; aop = 2'b01; br = 1; pcs = 2'b01; end
        else if (ph == "ADDIEX") begin asa = 1; asb = 2'b10; end
        else if (ph == "ITWB")   wrf = 1;
        else if (ph == "JEX")    begin pcw = 1; pcs = 2'b10; end
        else if (ph == "IMMEX")  begin asa = 1; asb = 2'b10; aop = 2'b11; end
        return {mreq, we, io, irw, pcw, br, pcs, wrf, rfw, m2r, asa, asb, aop};
    endfunction

    function automatic logic [15:0] ctrl_of(input bit sel);
        if (sel)
            return {ifb.mem_req, ifb.wemem, ifb.iord, ifb.irwrite, ifb.pcwrite, ifb.branch,
                    ifb.pcsrc, ifb.werf, ifb.rfwasrc, ifb.memToRf, ifb.alusrca, ifb.alusrcb, ifb.aluop};
        return {ifa.mem_req, ifa.wemem, ifa.iord, ifa.irwrite, ifa.pcwrite, ifa.branch,
                ifa.pcsrc, ifa.werf, ifa.rfwasrc, ifa.memToRf, ifa.alusrca, ifa.alusrcb, ifa.aluop};
    endfunction

    // One clock: drive, check between edges, then cross the rising edge
    task automatic cyc(input bit sel, input string ph, input bit rdy, input logic [5:0] op, input bit ill);
        logic [31:0] ret_obs, ret_exp;
        if (sel) begin ifb.mem_ready = 1'b0; ifb.opcode = op; end
        else     begin ifa.mem_ready = rdy;  ifa.opcode = op; end
        #1;
        ret_obs = sel ? {28'b0, ifb.retired} : ifa.retired;
        ret_exp = sel ? (model_ret & 32'hF) : model_ret;
        chk({ph, " ctrl"}, {16'b0, ctrl_of(sel)}, {16'b0, exp_ctrl(ph, sel ? 1'b1 : rdy)});
        chk({ph, " illegal"}, {31'b0, sel ? ifb.illegal : ifa.illegal}, {31'b0, ill});
        chk({ph, " retired"}, ret_obs, ret_exp);
        @(posedge clk);
        #1;
    endtask

    function automatic string ex_phase(input logic [5:0] op);
        if (op == RT)   return "RTEXEC";
        if (op == BEQ)  return "BEQEX";
        if (op == ADDI) return "ADDIEX";
        if (op == J)    return "JEX";
        if (op == LW || op == SW) return "MEMADR";
`ifdef MC_IMM_LOGIC_EN
        if (op == ANDI || op == ORI) return "IMMEX";
`endif
        return "";
    endfunction

    // Walk one instruction through the phases the spec lists for it;
    // opcode is scrambled wherever the controller must ignore it
    task automatic run_instr(input bit sel, input logic [5:0] op, input int wf, input int wm);
        string ex;
        ex = ex_phase(op);
        for (int k = 0; k < wf; k++) cyc(sel, "FETCH", 1'b0, 6'($urandom), 1'b0);
        cyc(sel, "FETCH", 1'b1, 6'($urandom), 1'b0);
        cyc(sel, "DECODE", 1'($urandom), op, ex == "");
        if (ex == "") return;
        cyc(sel, ex, 1'($urandom), op, 1'b0);
        if (op == LW) begin
            for (int k = 0; k < wm; k++) cyc(sel, "MEMRD", 1'b0, 6'($urandom), 1'b0);
            cyc(sel, "MEMRD", 1'b1, 6'($urandom), 1'b0);
            cyc(sel, "MEMWB", 1'($urandom), 6'($urandom), 1'b0);
        end else if (op == SW) begin
            for (int k = 0; k < wm; k++) cyc(sel, "MEMWR", 1'b0, 6'($urandom), 1'b0);
            cyc(sel, "MEMWR", 1'b1, 6'($urandom), 1'b0);
        end else if (op == RT) begin
            cyc(sel, "RTWB", 1'($urandom), 6'($urandom), 1'b0);
        end else if (op == ADDI || ex == "IMMEX") begin
            cyc(sel, "ITWB", 1'($urandom), 6'($urandom), 1'b0);
        end
        model_ret = model_ret + 1;
    endtask

    logic [5:0] pool [10] = '{LW, SW, RT, BEQ, ADDI, J, ANDI, ORI, 6'b111111, 6'b010101};

    initial begin
        ifa.opcode = 6'd0; ifa.mem_ready = 1'b0;
        ifb.opcode = 6'd0; ifb.mem_ready = 1'b0;
        #1;
        chk("reset ctrl", {16'b0, ctrl_of(1'b0)}, {16'b0, exp_ctrl("FETCH", 1'b0)});
        chk("reset retired", ifa.retired, 32'd0);
        chk("reset illegal", {31'b0, ifa.illegal}, 32'd0);
        @(posedge clk); #1;
        rst_na = 1'b1;

        run_instr(1'b0, LW, 0, 0);
        chk("lw retired", ifa.retired, 32'd1);
        run_instr(1'b0, SW, 0, 3);
        run_instr(1'b0, BEQ, 0, 0);
        run_instr(1'b0, J, 0, 0);
        chk("beq+j retired", ifa.retired, 32'd4);
        run_instr(1'b0, 6'b111111, 0, 0);
        run_instr(1'b0, ANDI, 0, 0);
        run_instr(1'b0, ORI, 1, 0);
        run_instr(1'b0, RT, 2, 0);
        run_instr(1'b0, ADDI, 0, 0);

        for (int i = 0; i < 60; i++)
            run_instr(1'b0, pool[$urandom_range(0, 9)], $urandom_range(0, 2), $urandom_range(0, 2));

        // Abort a load in MEMRD with an asynchronous reset between edges
        cyc(1'b0, "FETCH", 1'b1, 6'd0, 1'b0);
        cyc(1'b0, "DECODE", 1'b0, LW, 1'b0);
        cyc(1'b0, "MEMADR", 1'b0, LW, 1'b0);
        ifa.mem_ready = 1'b0;
        #1;
        chk("memrd iord", {31'b0, ifa.iord}, 32'd1);
        rst_na = 1'b0;
        #1;
        chk("abort ctrl", {16'b0, ctrl_of(1'b0)}, {16'b0, exp_ctrl("FETCH", 1'b0)});
        chk("abort retired", ifa.retired, 32'd0);
        chk("abort wemem", {31'b0, ifa.wemem}, 32'd0);
        chk("abort werf", {31'b0, ifa.werf}, 32'd0);
        model_ret = 0;
        @(posedge clk); #1;
        rst_na = 1'b1;
        run_instr(1'b0, LW, 1, 1);

        // 4-bit counter, no handshake: mem_ready held low, FETCH still advances
        model_ret = 0;
        rst_nb = 1'b1;
        for (int i = 0; i < 17; i++) run_instr(1'b1, RT, 0, 0);
        #1;
        chk("wrap retired", {28'b0, ifb.retired}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
